ahb_bus_arbiter: RTL and testbench

- Round-robin arbiter that shares one AHB-Lite slave-side bus (decoder, slaves, default slave) between up to NUM_MASTERS masters.
- Grants address-phase ownership and tracks fixed-length bursts and locked sequences so that ownership never changes mid-burst.
- Produces HMASTER (address-phase owner) and HMASTER_DATA (data-phase owner) for the external address/control mux and write-data mux.
- Parks the bus on master 0 when no master is requesting.

---
 rtl/ahb_pkg.sv | 54 +++++
 rtl/ahb_rr_picker.sv | 35 +++
 rtl/ahb_bus_arbiter.sv | 163 ++++++++++++++++
 tb/tb_ahb_bus_arbiter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and arbiter definitions.
// Latency: n/a (types, constants and one pure function).
// Backpressure: n/a.
// Contents: HTRANS/HBURST/HRESP encodings, arbiter state type, burst length helper.
package ahb_pkg;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_BUSY   = 2'b01,
        TRANS_NONSEQ = 2'b10,
        TRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        BURST_SINGLE = 3'b000,
        BURST_INCR   = 3'b001,
        BURST_WRAP4  = 3'b010,
        BURST_INCR4  = 3'b011,
        BURST_WRAP8  = 3'b100,
        BURST_INCR8  = 3'b101,
        BURST_WRAP16 = 3'b110,
        BURST_INCR16 = 3'b111
    } hburst_e;

    typedef enum logic [1:0] {
        RESP_OKAY  = 2'b00,
        RESP_ERROR = 2'b01,
        RESP_RETRY = 2'b10,
        RESP_SPLIT = 2'b11
    } hresp_e;

    typedef enum logic [1:0] {
        ST_ARB    = 2'b00,
        ST_BURST  = 2'b01,
        ST_LOCKED = 2'b10
    } arb_state_e;

    localparam int BEAT_CNT_WIDTH = 4;

    // Beats remaining after the NONSEQ beat of a fixed-length burst.
    // Zero means "not a fixed-length burst" (SINGLE or undefined INCR).
    function automatic logic [BEAT_CNT_WIDTH-1:0] burst_beats_m1(input logic [2:0] hburst);
        logic [BEAT_CNT_WIDTH-1:0] beats;
        beats = '0;
        case (hburst)
            BURST_WRAP4,  BURST_INCR4:  beats = 4'd3;
            BURST_WRAP8,  BURST_INCR8:  beats = 4'd7;
            BURST_WRAP16, BURST_INCR16: beats = 4'd15;
            default:                    beats = '0;
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Round-robin winner search starting one past ptr, wrapping modulo num_masters.
// Latency: purely combinational.
// Backpressure: none; ports are req (request vector), ptr (last winner),
// idx (winner index, 0 when none) and none (no request bit set).
module ahb_rr_picker #(
    parameter int NUM_MASTERS = 4,
    parameter int MIDX_WIDTH  = 2
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [MIDX_WIDTH-1:0]  ptr,
    output logic [MIDX_WIDTH-1:0]  idx,
    output logic                   none
);

    int cand;

    // Offsets 1..NUM_MASTERS visit every master once, with ptr itself last,
    // so a sole requester that already owns the bus re-wins immediately.
    always_comb begin
        idx  = '0;
        none = 1'b1;
        cand = 0;
        for (int off = 1; off <= NUM_MASTERS; off++) begin
            cand = int'(ptr) + off;
            if (cand >= NUM_MASTERS) begin
                cand = cand - NUM_MASTERS;
            end
            if (none && req[cand[MIDX_WIDTH-1:0]]) begin
                idx  = cand[MIDX_WIDTH-1:0];
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB-Lite bus arbiter with fixed-burst and locked-sequence tracking.
// Latency: grant/HMASTER registered, one HCLK after the deciding edge; HMASTER_DATA lags HMASTER by one accepted edge.
// Backpressure: every state update is qualified by HREADY; with HREADY low all state holds.
// Ports: HCLK/HRESET (sync, active-high); HBUSREQ/HLOCK per master; HTRANS/HBURST/HREADY/HRESP
// observed on the shared bus; HGRANT (one-hot), HMASTER, HMASTER_DATA, HMASTLOCK registered outputs.
module ahb_bus_arbiter
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int MIDX_WIDTH  = 2
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [NUM_MASTERS-1:0] HBUSREQ,
    input  logic [NUM_MASTERS-1:0] HLOCK,
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HBURST,
    input  logic                   HREADY,
    input  logic [1:0]             HRESP,
    output logic [NUM_MASTERS-1:0] HGRANT,
    output logic [MIDX_WIDTH-1:0]  HMASTER,
    output logic [MIDX_WIDTH-1:0]  HMASTER_DATA,
    output logic                   HMASTLOCK
);

    localparam logic [NUM_MASTERS-1:0] GRANT_ONE = NUM_MASTERS'(1);

    arb_state_e                state, state_nxt;
    logic [BEAT_CNT_WIDTH-1:0] beat_cnt, beat_nxt;
    logic [MIDX_WIDTH-1:0]     rr_ptr, rr_nxt;
    logic [MIDX_WIDTH-1:0]     owner_nxt;
    logic                      lock_nxt;

    logic [MIDX_WIDTH-1:0]     pick_idx;
    logic                      pick_none;
    logic [MIDX_WIDTH-1:0]     winner;

    logic                      owner_lock;
    logic [BEAT_CNT_WIDTH-1:0] start_len;
    logic                      fixed_start;
    logic                      run_rules;
    logic                      rearb;

    ahb_rr_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .MIDX_WIDTH  (MIDX_WIDTH)
    ) u_picker (
        .req  (HBUSREQ),
        .ptr  (rr_ptr),
        .idx  (pick_idx),
        .none (pick_none)
    );

    // Park on master 0 when nobody requests.
    assign winner      = pick_none ? '0 : pick_idx;
    assign owner_lock  = HLOCK[HMASTER];
    assign start_len   = burst_beats_m1(HBURST);
    assign fixed_start = (HTRANS == TRANS_NONSEQ) && (start_len != '0);

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat_cnt;
        owner_nxt = HMASTER;
        lock_nxt  = HMASTLOCK;
        rr_nxt    = rr_ptr;
        run_rules = 1'b0;
        rearb     = 1'b0;

        if (HREADY) begin
            case (state)
                ST_ARB: begin
                    run_rules = 1'b1;
                end

                ST_BURST: begin
                    if (HTRANS == TRANS_SEQ) begin
                        // Final beat accepted: hand over on this same edge unless
                        // the owner is also asking for a locked sequence.
                        if (beat_cnt <= 4'd1) begin
                            beat_nxt = '0;
                            if (owner_lock) begin
                                state_nxt = ST_LOCKED;
                                lock_nxt  = 1'b1;
                            end else begin
                                state_nxt = ST_ARB;
                                rearb     = 1'b1;
                            end
                        end else begin
                            beat_nxt = beat_cnt - 4'd1;
                        end
                    end else if (HTRANS != TRANS_BUSY) begin
                        // IDLE or NONSEQ ends the burst early (e.g. after an
                        // ERROR); the new transfer is judged as if in ARB.
                        beat_nxt  = '0;
                        state_nxt = ST_ARB;
                        run_rules = 1'b1;
                    end
                end

                ST_LOCKED: begin
                    if (!owner_lock && (HTRANS != TRANS_SEQ) && (HTRANS != TRANS_BUSY)) begin
                        lock_nxt  = 1'b0;
                        state_nxt = ST_ARB;
                        beat_nxt  = '0;
                        rearb     = 1'b1;
                    end else if (fixed_start) begin
                        // Bursts inside a locked sequence are counted but the
                        // lock alone decides when ownership is released.
                        beat_nxt = start_len;
                    end else if ((HTRANS == TRANS_SEQ) && (beat_cnt != '0)) begin
                        beat_nxt = beat_cnt - 4'd1;
                    end
                end

                default: begin
                    state_nxt = ST_ARB;
                    beat_nxt  = '0;
                    lock_nxt  = 1'b0;
                end
            endcase

            if (run_rules) begin
                if (fixed_start) begin
                    beat_nxt  = start_len;
                    state_nxt = ST_BURST;
                end else if (owner_lock && (HTRANS != TRANS_IDLE)) begin
                    lock_nxt  = 1'b1;
                    state_nxt = ST_LOCKED;
                end else begin
                    rearb = 1'b1;
                end
            end

            if (rearb) begin
                owner_nxt = winner;
                if (winner != HMASTER) begin
                    rr_nxt = winner;
                end
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state        <= ST_ARB;
            beat_cnt     <= '0;
            rr_ptr       <= '0;
            HGRANT       <= GRANT_ONE;
            HMASTER      <= '0;
            HMASTER_DATA <= '0;
            HMASTLOCK    <= 1'b0;
        end else if (HREADY) begin
            state        <= state_nxt;
            beat_cnt     <= beat_nxt;
            rr_ptr       <= rr_nxt;
            HGRANT       <= GRANT_ONE << owner_nxt;
            HMASTER      <= owner_nxt;
            HMASTER_DATA <= HMASTER;
            HMASTLOCK    <= lock_nxt;
        end
    end

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Self-checking bench for ahb_bus_arbiter: expected owner/lock pushed per driven cycle,
// popped and compared one clock later. HMASTER_DATA expectation follows the expected
// address-phase owner with one accepted-edge lag.
module tb_ahb_bus_arbiter;

    logic       HCLK;
    logic       HRESET;
    logic [3:0] HBUSREQ;
    logic [3:0] HLOCK;
    logic [1:0] HTRANS;
    logic [2:0] HBURST;
    logic       HREADY;
    logic [1:0] HRESP;
    logic [3:0] HGRANT;
    logic [1:0] HMASTER;
    logic [1:0] HMASTER_DATA;
    logic       HMASTLOCK;

    localparam logic [1:0] IDL = 2'b00, BSY = 2'b01, NSQ = 2'b10, SEQ = 2'b11;
    localparam logic [2:0] SGL = 3'd0, INC = 3'd1, WR4 = 3'd2, IN4 = 3'd3, WR8 = 3'd4, I16 = 3'd7;
    localparam logic [1:0] OK = 2'b00, ERR = 2'b01;

    typedef struct packed {
        logic [2:0] m;
        logic [2:0] d;
        logic       l;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   model_m  = 0;
    int   model_d  = 0;

    ahb_bus_arbiter #(
        .NUM_MASTERS (4),
        .MIDX_WIDTH  (2)
    ) dut (
        .HCLK         (HCLK),
        .HRESET       (HRESET),
        .HBUSREQ      (HBUSREQ),
        .HLOCK        (HLOCK),
        .HTRANS       (HTRANS),
        .HBURST       (HBURST),
        .HREADY       (HREADY),
        .HRESP        (HRESP),
        .HGRANT       (HGRANT),
        .HMASTER      (HMASTER),
        .HMASTER_DATA (HMASTER_DATA),
        .HMASTLOCK    (HMASTLOCK)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of bus inputs, record what the outputs must be after the
    // edge, then pop that expectation and compare.
    task automatic step(input string tag, input bit rst, input logic [3:0] req,
                        input logic [3:0] lck, input logic [1:0] tr, input logic [2:0] bu,
                        input bit rdy, input logic [1:0] rsp, input int em, input bit el);
        exp_t e;
        logic [31:0] one;
        HRESET  = rst;
        HBUSREQ = req;
        HLOCK   = lck;
        HTRANS  = tr;
        HBURST  = bu;
        HREADY  = rdy;
        HRESP   = rsp;
        if (rst) begin
            model_m = 0;
            model_d = 0;
        end else begin
            if (rdy) model_d = model_m;
            model_m = em;
        end
        e.m = 3'(model_m);
        e.d = 3'(model_d);
        e.l = rst ? 1'b0 : el;
        sb.push_back(e);
        @(posedge HCLK);
        #1;
        e = sb.pop_front();
        one = 32'd1;
        check_eq({tag, ".hmaster"}, 32'(HMASTER), 32'(e.m));
        check_eq({tag, ".hmaster_data"}, 32'(HMASTER_DATA), 32'(e.d));
        check_eq({tag, ".hmastlock"}, 32'(HMASTLOCK), 32'(e.l));
        check_eq({tag, ".hgrant"}, 32'(HGRANT), one << e.m);
    endtask

    initial begin
        HRESET = 1'b1; HBUSREQ = '0; HLOCK = '0; HTRANS = IDL;
        HBURST = SGL; HREADY = 1'b1; HRESP = OK;

        // Reset, then idle parking on master 0.
        step("reset", 1, 4'b0000, 4'b0000, IDL, SGL, 1, OK, 0, 0);
        for (int i = 0; i < 5; i++)
            step("park", 0, 4'b0000, 4'b0000, IDL, SGL, 1, OK, 0, 0);

        // All request, SINGLE transfers: 1,2,3,0,1.
        begin
            int seq_m[5] = '{1, 2, 3, 0, 1};
            for (int i = 0; i < 5; i++)
                step("rr_single", 0, 4'b1111, 4'b0000, NSQ, SGL, 1, OK, seq_m[i], 0);
        end

        // Master 2 INCR4 with two wait states, master 3 waiting.
        step("to_m2", 0, 4'b0100, 4'b0000, IDL, SGL, 1, OK, 2, 0);
        step("incr4_ns", 0, 4'b1100, 4'b0000, NSQ, IN4, 1, OK, 2, 0);
        step("incr4_wait1", 0, 4'b1100, 4'b0000, SEQ, IN4, 0, ERR, 2, 0);
        step("incr4_wait2", 0, 4'b1100, 4'b0000, SEQ, IN4, 0, OK, 2, 0);
        step("incr4_b2", 0, 4'b1100, 4'b0000, SEQ, IN4, 1, OK, 2, 0);
        step("incr4_b3", 0, 4'b1100, 4'b0000, SEQ, IN4, 1, OK, 2, 0);
        step("incr4_last", 0, 4'b1100, 4'b0000, SEQ, IN4, 1, OK, 3, 0);

        // Master 1 WRAP8 cut short by ERROR then IDLE.
        step("to_m1", 0, 4'b0010, 4'b0000, IDL, SGL, 1, OK, 1, 0);
        step("wrap8_ns", 0, 4'b1010, 4'b0000, NSQ, WR8, 1, OK, 1, 0);
        step("wrap8_b1", 0, 4'b1010, 4'b0000, SEQ, WR8, 1, OK, 1, 0);
        step("wrap8_b2", 0, 4'b1010, 4'b0000, SEQ, WR8, 1, OK, 1, 0);
        step("wrap8_err1", 0, 4'b1010, 4'b0000, SEQ, WR8, 0, ERR, 1, 0);
        step("wrap8_idle", 0, 4'b1010, 4'b0000, IDL, WR8, 1, ERR, 3, 0);

        // Master 1 locked sequence of three transfers, 0 and 2 requesting.
        step("to_m1b", 0, 4'b0010, 4'b0000, IDL, SGL, 1, OK, 1, 0);
        for (int i = 0; i < 3; i++)
            step("locked", 0, 4'b0111, 4'b0010, NSQ, SGL, 1, OK, 1, 1);
        step("unlock", 0, 4'b0111, 4'b0000, IDL, SGL, 1, OK, 2, 0);

        // Sole requester keeps the bus; dropping all requests parks on 0.
        step("sole1", 0, 4'b0100, 4'b0000, IDL, SGL, 1, OK, 2, 0);
        step("sole2", 0, 4'b0100, 4'b0000, IDL, SGL, 1, OK, 2, 0);
        step("repark", 0, 4'b0000, 4'b0000, IDL, SGL, 1, OK, 0, 0);
        step("to_m3", 0, 4'b1000, 4'b0000, NSQ, SGL, 1, OK, 3, 0);

        // Last burst beat coinciding with HLOCK enters LOCKED.
        step("lk_ns", 0, 4'b1001, 4'b1000, NSQ, WR4, 1, OK, 3, 0);
        step("lk_b1", 0, 4'b1001, 4'b1000, SEQ, WR4, 1, OK, 3, 0);
        step("lk_bsy", 0, 4'b1001, 4'b1000, BSY, WR4, 1, OK, 3, 0);
        step("lk_b2", 0, 4'b1001, 4'b1000, SEQ, WR4, 1, OK, 3, 0);
        step("lk_last", 0, 4'b1001, 4'b1000, SEQ, WR4, 1, OK, 3, 1);
        step("lk_hold", 0, 4'b1001, 4'b1000, IDL, SGL, 1, OK, 3, 1);
        step("lk_rel", 0, 4'b1001, 4'b0000, IDL, SGL, 1, OK, 0, 0);

        // Reset mid-INCR16 with beat_cnt at 9.
        step("to_m2c", 0, 4'b0100, 4'b0000, IDL, SGL, 1, OK, 2, 0);
        step("i16_ns", 0, 4'b1100, 4'b0000, NSQ, I16, 1, OK, 2, 0);
        for (int i = 0; i < 6; i++)
            step("i16_seq", 0, 4'b1100, 4'b0000, SEQ, I16, 1, OK, 2, 0);
        step("i16_rst", 1, 4'b1100, 4'b0000, SEQ, I16, 1, OK, 0, 0);
        // A SEQ in ARB re-arbitrates from rr_ptr=0; a stale BURST would hold master 0.
        step("post_rst", 0, 4'b1100, 4'b0000, SEQ, I16, 1, OK, 2, 0);

        // Undefined-length INCR does not hold the bus against another requester.
        step("incr_open", 0, 4'b1100, 4'b0000, NSQ, INC, 1, OK, 3, 0);

        // HREADY low in ARB holds everything.
        step("ready_low", 0, 4'b0001, 4'b0000, IDL, SGL, 0, OK, 3, 0);
        step("ready_high", 0, 4'b0001, 4'b0000, IDL, SGL, 1, OK, 0, 0);

        if (sb.size() != 0)
            check_eq("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
